// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the multiplier/adder result paths.
//   EXP_W / FRAC_W : IEEE-754 single-precision field widths
//   EXP_MAX        : all-ones exponent (Inf/NaN)
//   QNAN           : canonical quiet NaN
//   NV/OF/UF/ZR    : bit positions inside the 4-bit status vector
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;

  localparam int NV = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int ZR = 0;

  typedef logic [3:0] status_t;

  // Packed word plus the event bits it raises.
  typedef struct packed {
    status_t           ev;
    logic [WORD_W-1:0] word;
  } pack_t;

endpackage

// File: rtl/fpu_out_fifo.sv
// Two-entry circular output buffer with valid/ready on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   push_valid_i/_ready_o, push_data_i : upstream side
//   pop_valid_o, pop_ready_i, pop_data_o : downstream side (head of buffer)
//   pop_fire_o        : an entry leaves this cycle
// Accepting while full is allowed when the head leaves in the same cycle.
module fpu_out_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o,
  output logic         pop_fire_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0][W-1:0] mem_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              push, pop;

  assign pop_valid_o  = (cnt_q != 2'd0);
  assign pop          = pop_valid_o & pop_ready_i;
  assign push_ready_o = (cnt_q != FULL) | pop;
  assign push         = push_valid_i & push_ready_o;
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign pop_fire_o   = pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      // push+pop together leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mul_result_packer.sv
// Final multiplier stage: applies exception priority, packs the IEEE-754
// word on entry, buffers it in a 2-entry FIFO and keeps sticky status.
//   CLK, RST             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake
//   sign_z, Ez, Mz       : normalized sign / biased exponent / fraction
//   invalid_flag, overflow_flag, initial_zero_flag : exception flags
//   result, out_valid, out_ready : downstream handshake, head of buffer
//   status               : sticky {NV, OF, UF, ZR}; clear_status clears it
//   result_count         : results delivered since reset (wraps)
module mul_result_packer
  import fpu_pkg::*;
#(
  parameter logic [31:0] QNAN  = fpu_pkg::QNAN,
  parameter int          DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_z,
  input  logic [7:0]  Ez,
  input  logic [22:0] Mz,
  input  logic        invalid_flag,
  input  logic        overflow_flag,
  input  logic        initial_zero_flag,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  status,
  input  logic        clear_status,
  output logic [15:0] result_count
);

  pack_t       pk;
  logic        accept, pop_fire;
  status_t     status_q, status_d;
  logic [15:0] cnt_q, cnt_d;

  // Exception priority: invalid > overflow > zero > denormal flush > normal.
  always_comb begin
    pk.word = {sign_z, Ez, Mz};
    pk.ev   = '0;
    if (invalid_flag) begin
      pk.word     = {1'b0, QNAN[30:0]};
      pk.ev[NV]   = 1'b1;
    end else if (overflow_flag) begin
      pk.word     = {sign_z, EXP_MAX, {FRAC_W{1'b0}}};
      pk.ev[OF]   = 1'b1;
    end else if (initial_zero_flag) begin
      pk.word     = {sign_z, 31'h0};
      pk.ev[ZR]   = 1'b1;
    end else if ((Ez == '0) && (Mz != '0)) begin
      // subnormal results are not supported; flush to signed zero
      pk.word     = {sign_z, 31'h0};
      pk.ev[UF]   = 1'b1;
    end
  end

  fpu_out_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .rst         (RST),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i (pk.word),
    .pop_valid_o (out_valid),
    .pop_ready_i (out_ready),
    .pop_data_o  (result),
    .pop_fire_o  (pop_fire)
  );

  assign accept = in_valid & in_ready;

  // Clear happens first so a same-cycle event survives it.
  always_comb begin
    status_d = (clear_status ? '0 : status_q) | (accept ? pk.ev : '0);
    cnt_d    = pop_fire ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status       = status_q;
  assign result_count = cnt_q;

endmodule

// File: tb/tb_mul_result_packer.sv
module tb_mul_result_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready;
  logic        sign_z;
  logic [7:0]  Ez;
  logic [22:0] Mz;
  logic        invalid_flag, overflow_flag, initial_zero_flag;
  logic [31:0] result;
  logic        out_valid, out_ready;
  logic [3:0]  status;
  logic        clear_status;
  logic [15:0] result_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  logic [31:0] sb[$];

  always #5 CLK = ~CLK;

  mul_result_packer dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_z(sign_z), .Ez(Ez), .Mz(Mz),
    .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
    .initial_zero_flag(initial_zero_flag),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .status(status), .clear_status(clear_status),
    .result_count(result_count)
  );

  function automatic logic [31:0] model(input logic s, input logic [7:0] e,
                                        input logic [22:0] m, input logic nv,
                                        input logic ov, input logic zr);
    if (nv)                    return 32'h7FC0_0000;
    if (ov)                    return {s, 8'hFF, 23'h0};
    if (zr)                    return {s, 31'h0};
    if (e == 8'h0 && m != 0)   return {s, 31'h0};
    return {s, e, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic nv, input logic ov, input logic zr);
    in_valid = 1'b1; sign_z = s; Ez = e; Mz = m;
    invalid_flag = nv; overflow_flag = ov; initial_zero_flag = zr;
  endtask

  // Scoreboard: pop/compare on every handshake, push expected on every accept.
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL sb_underflow observed=%h expected=<none>", result);
        end else begin
          chk("fifo_out", result, sb.pop_front());
          pops++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(sign_z, Ez, Mz, invalid_flag, overflow_flag, initial_zero_flag));
    end
  end

  initial begin
    RST = 1'b1; in_valid = 0; sign_z = 0; Ez = 0; Mz = 0;
    invalid_flag = 0; overflow_flag = 0; initial_zero_flag = 0;
    out_ready = 0; clear_status = 0;
    step(); step();
    RST = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    chk("rst_count", result_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // normal operand
    out_ready = 1;
    drive(0, 8'h80, 23'h400000, 0, 0, 0);
    step(); in_valid = 0;
    chk("norm_valid", out_valid, 1);
    chk("norm_result", result, 32'h4040_0000);
    chk("norm_status", status, 4'b0000);
    step();
    chk("norm_count", result_count, 1);
    chk("norm_empty", out_valid, 0);

    // invalid wins over overflow, sign forced to 0
    drive(1, 8'h90, 23'h123, 1, 1, 0);
    step(); in_valid = 0;
    chk("nv_result", result, 32'h7FC0_0000);
    chk("nv_status", status, 4'b1000);
    step();
    chk("nv_count", result_count, 2);
    clear_status = 1; step(); clear_status = 0;
    chk("clear_status", status, 4'b0000);

    // backpressure: two accepts fill the buffer, third is held
    out_ready = 0;
    drive(0, 8'h01, 23'h000001, 0, 0, 0); step();
    drive(1, 8'h7F, 23'h000000, 0, 0, 0); step();
    drive(0, 8'h81, 23'h200000, 0, 0, 0);
    chk("full_in_ready", in_ready, 0);
    step(); step();
    chk("held_in_ready", in_ready, 0);
    chk("held_result", result, 32'h0080_0001);
    // full with simultaneous push and pop
    out_ready = 1; #1;
    chk("pushpop_in_ready", in_ready, 1);
    step();
    in_valid = 0; out_ready = 0; #1;
    chk("pushpop_still_full", in_ready, 0);
    chk("pushpop_head", result, 32'hBF80_0000);
    out_ready = 1;
    step(); step();
    chk("bp_drained", out_valid, 0);
    chk("bp_count", result_count, 5);

    // denormal flush raises UF
    drive(1, 8'h00, 23'h000001, 0, 0, 0);
    step(); in_valid = 0;
    chk("uf_result", result, 32'h8000_0000);
    chk("uf_status", status, 4'b0010);
    step();
    // clear in the same cycle as an overflow accept keeps OF
    drive(0, 8'h10, 23'h7, 0, 1, 0); clear_status = 1;
    step(); in_valid = 0; clear_status = 0;
    chk("clr_of_status", status, 4'b0100);
    chk("of_result", result, 32'h7F80_0000);
    step();
    drive(1, 8'h55, 23'h55, 0, 0, 1);
    step(); in_valid = 0;
    chk("zr_result", result, 32'h8000_0000);
    chk("zr_status", status, 4'b0101);
    step();

    // random traffic through the scoreboard
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("drain_bound", sb.size(), 0);
    chk("rand_count", result_count, 16'(pops));

    // reset with two results buffered
    out_ready = 0;
    drive(0, 8'h80, 23'h1, 0, 0, 0); step();
    drive(1, 8'h81, 23'h2, 0, 1, 0); step();
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    RST = 1; sb.delete();
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_count", result_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_result", result, 0);
    RST = 0; pops = 0;
    out_ready = 1;
    drive(0, 8'h7E, 23'h0, 0, 0, 0);
    step(); in_valid = 0;
    chk("post_rst_result", result, 32'h3F00_0000);
    step();
    chk("post_rst_count", result_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
